// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the ALU/register-heap datapath: accepts one command, drives
// read/write addresses and opcode, waits the ALU latency, optionally writes back, then responds.
module alu_cmd_sequencer #(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned ZERO_RO = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [3:0]       cmd_op_i,
    input  logic [4:0]       cmd_ra_i,
    input  logic [4:0]       cmd_rb_i,
    input  logic [4:0]       cmd_rd_i,
    input  logic             cmd_wb_i,
    output logic [4:0]       r_addr_a_o,
    output logic [4:0]       r_addr_b_o,
    output logic [4:0]       w_addr_o,
    output logic [3:0]       alu_op_o,
    output logic             w_en_o,
    input  logic [31:0]      res_i,
    input  logic [3:0]       flags_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_res_o,
    output logic [3:0]       rsp_flags_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);
    localparam logic       ZRO      = (ZERO_RO != 0);

    state_t           state_q, state_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic [4:0]       ra_q, ra_d;
    logic [4:0]       rb_q, rb_d;
    logic [4:0]       rd_q, rd_d;
    logic [3:0]       op_q, op_d;
    logic             wb_q, wb_d;
    logic [31:0]      res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             w_en_q, w_en_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rd_d        = rd_q;
        op_d        = op_q;
        wb_d        = wb_q;
        res_d       = res_q;
        flags_d     = flags_q;
        w_en_d      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    ra_d      = cmd_ra_i;
                    rb_d      = cmd_rb_i;
                    rd_d      = cmd_rd_i;
                    op_d      = cmd_op_i;
                    wb_d      = cmd_wb_i;
                    lat_cnt_d = LAT_INIT;
                    state_d   = ST_EXEC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == 4'd0) begin
                    res_d   = res_i;
                    flags_d = flags_i;
                    // Write-back to x0 is suppressed when the zero register is read-only
                    w_en_d  = wb_q && !(ZRO && (rd_q == 5'd0));
                    state_d = ST_WB;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_WB: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= 4'd0;
            ra_q        <= 5'd0;
            rb_q        <= 5'd0;
            rd_q        <= 5'd0;
            op_q        <= 4'd0;
            wb_q        <= 1'b0;
            res_q       <= 32'd0;
            flags_q     <= 4'd0;
            w_en_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rd_q        <= rd_d;
            op_q        <= op_d;
            wb_q        <= wb_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            w_en_q      <= w_en_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign r_addr_a_o  = ra_q;
    assign r_addr_b_o  = rb_q;
    assign w_addr_o    = rd_q;
    assign alu_op_o    = op_q;
    assign w_en_o      = w_en_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_res_o   = res_q;
    assign rsp_flags_o = flags_q;
    assign busy_o      = busy_q;
    assign done_cnt_o  = done_cnt_q;

endmodule
